// File: rtl/btb_update_ctrl_if.sv
// EXE resolution inputs, redirect and BTB write-port outputs of btb_update_ctrl.
// Slave is the controller; master is the EXE/BTB side that drives and observes it.
interface btb_update_ctrl_if #(
  parameter int IDX_W = 3
);
  logic             res_valid;
  logic [31:0]      res_pc;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             res_pred_taken;
  logic [31:0]      res_pred_addr;
  logic             flush_req;
  logic             stall_exe;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             btb_update_flag;
  logic [31:0]      btb_pc;
  logic             btb_taken;
  logic [31:0]      btb_target;
  logic             btb_inv_valid;
  logic [IDX_W-1:0] btb_inv_index;
  logic             busy;
  logic [31:0]      branch_cnt;
  logic [31:0]      mispred_cnt;

  modport slave (
    input  res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_addr, flush_req,
    output stall_exe, redirect_valid, redirect_pc, btb_update_flag, btb_pc, btb_taken,
           btb_target, btb_inv_valid, btb_inv_index, busy, branch_cnt, mispred_cnt
  );

  modport master (
    output res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_addr, flush_req,
    input  stall_exe, redirect_valid, redirect_pc, btb_update_flag, btb_pc, btb_taken,
           btb_target, btb_inv_valid, btb_inv_index, busy, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: FIFO'd resolution updates (>=1 cycle to BTB port), registered redirect,
// whole-table invalidate walk; EXE stalled while FIFO full, invalidating, or on flush_req.
module btb_update_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = 3
) (
  input  logic               clk,
  input  logic               rst,
  btb_update_ctrl_if.slave   bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic {IDLE, INVAL} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   inv_idx_q, inv_idx_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [31:0]        branch_cnt_q, branch_cnt_d;
  logic [31:0]        mispred_cnt_q, mispred_cnt_d;

  logic [31:0]        pc_mem_q     [FIFO_DEPTH];
  logic               taken_mem_q  [FIFO_DEPTH];
  logic [31:0]        target_mem_q [FIFO_DEPTH];

  logic stall, accept, pop, mispredict, fifo_clear;

  always_comb begin
    stall      = (count_q == CNT_W'(FIFO_DEPTH)) | (state_q != IDLE) | bus.flush_req;
    accept     = bus.res_valid & ~stall;
    pop        = (count_q != '0) & (state_q == IDLE);
    fifo_clear = (state_q == IDLE) & bus.flush_req;
    mispredict = accept & ((bus.res_taken != bus.res_pred_taken) |
                 (bus.res_taken & bus.res_pred_taken & (bus.res_pred_addr != bus.res_target)));

    state_d          = state_q;
    inv_idx_d        = inv_idx_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d   = INVAL;
          inv_idx_d = '0;
        end
      end
      INVAL: begin
        if (inv_idx_q == LAST_IDX) begin
          state_d   = IDLE;
          inv_idx_d = '0;
        end else begin
          inv_idx_d = inv_idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush discards whatever is queued, including the head being drained this cycle.
    if (fifo_clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end

    if (accept) branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispredict) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
      redirect_pc_d = bus.res_taken ? bus.res_target : (bus.res_pc + 32'd4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      inv_idx_q        <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      inv_idx_q        <= inv_idx_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem_q[wr_ptr_q]     <= bus.res_pc;
      taken_mem_q[wr_ptr_q]  <= bus.res_taken;
      target_mem_q[wr_ptr_q] <= bus.res_target;
    end
  end

  assign bus.stall_exe       = stall;
  assign bus.redirect_valid  = redirect_valid_q;
  assign bus.redirect_pc     = redirect_pc_q;
  assign bus.btb_update_flag = pop;
  assign bus.btb_pc          = (count_q != '0) ? pc_mem_q[rd_ptr_q]     : 32'd0;
  assign bus.btb_taken       = (count_q != '0) ? taken_mem_q[rd_ptr_q]  : 1'b0;
  assign bus.btb_target      = (count_q != '0) ? target_mem_q[rd_ptr_q] : 32'd0;
  assign bus.btb_inv_valid   = (state_q == INVAL);
  assign bus.btb_inv_index   = inv_idx_q;
  assign bus.busy            = (state_q == INVAL);
  assign bus.branch_cnt      = branch_cnt_q;
  assign bus.mispred_cnt     = mispred_cnt_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: driver predicts BTB writes, redirects and walks into
// queues; a negedge monitor pops them whenever the DUT presents an output.
module tb_btb_update_ctrl;
  localparam int DEPTH = 4;
  localparam int NUM   = 8;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btb_update_ctrl_if #(.IDX_W(IDX_W)) bus_if ();

  btb_update_ctrl #(.FIFO_DEPTH(DEPTH), .NUM_ENTRIES(NUM), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } upd_t;

  int          total = 0;
  int          bad   = 0;
  upd_t        exp_q[$];
  logic [31:0] redir_q[$];
  int          inval_left = 0;
  logic [31:0] m_branch = 0, m_mispred = 0, m_last_rpc = 0;
  bit          mon_en = 0;
  bit          cur_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    redir_q.delete();
    inval_left = 0;
    m_branch   = 0;
    m_mispred  = 0;
    m_last_rpc = 0;
  endtask

  // One cycle of stimulus; the reference model advances at the rising edge.
  task automatic step(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] paddr, input bit fl);
    bit   was_busy, acc;
    upd_t u;
    @(negedge clk);
    bus_if.res_valid      = v;
    bus_if.res_pc         = pc;
    bus_if.res_taken      = tk;
    bus_if.res_target     = tgt;
    bus_if.res_pred_taken = ptk;
    bus_if.res_pred_addr  = paddr;
    bus_if.flush_req      = fl;
    #1;
    cur_stall = (exp_q.size() == DEPTH) || (inval_left > 0) || fl;
    chk("stall_exe", {31'b0, bus_if.stall_exe}, {31'b0, cur_stall});
    @(posedge clk);
    was_busy = (inval_left > 0);
    acc      = v && !cur_stall;
    if (was_busy) inval_left--;
    else if (fl) begin
      exp_q.delete();
      inval_left = NUM;
    end
    if (acc) begin
      u.pc = pc; u.taken = tk; u.tgt = tgt;
      exp_q.push_back(u);
      m_branch++;
      if ((tk != ptk) || (tk && (paddr != tgt))) begin
        redir_q.push_back(tk ? tgt : pc + 32'd4);
        m_mispred++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    bit   ef, rv;
    upd_t e;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        ef = (exp_q.size() != 0) && (inval_left == 0);
        chk("btb_update_flag", {31'b0, bus_if.btb_update_flag}, {31'b0, ef});
        if (ef) begin
          e = exp_q.pop_front();
          chk("btb_pc", bus_if.btb_pc, e.pc);
          chk("btb_taken", {31'b0, bus_if.btb_taken}, {31'b0, e.taken});
          chk("btb_target", bus_if.btb_target, e.tgt);
        end
        chk("busy", {31'b0, bus_if.busy}, {31'b0, inval_left > 0});
        chk("btb_inv_valid", {31'b0, bus_if.btb_inv_valid}, {31'b0, inval_left > 0});
        if (inval_left > 0)
          chk("btb_inv_index", {29'b0, bus_if.btb_inv_index}, 32'(NUM - inval_left));
        rv = (redir_q.size() != 0);
        chk("redirect_valid", {31'b0, bus_if.redirect_valid}, {31'b0, rv});
        if (rv) m_last_rpc = redir_q.pop_front();
        chk("redirect_pc", bus_if.redirect_pc, m_last_rpc);
        chk("branch_cnt", bus_if.branch_cnt, m_branch);
        chk("mispred_cnt", bus_if.mispred_cnt, m_mispred);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, bus_if.busy}, 32'd0);
    chk({tag, "_inv_valid"}, {31'b0, bus_if.btb_inv_valid}, 32'd0);
    chk({tag, "_inv_index"}, {29'b0, bus_if.btb_inv_index}, 32'd0);
    chk({tag, "_update_flag"}, {31'b0, bus_if.btb_update_flag}, 32'd0);
    chk({tag, "_redirect_valid"}, {31'b0, bus_if.redirect_valid}, 32'd0);
    chk({tag, "_redirect_pc"}, bus_if.redirect_pc, 32'd0);
    chk({tag, "_branch_cnt"}, bus_if.branch_cnt, 32'd0);
    chk({tag, "_mispred_cnt"}, bus_if.mispred_cnt, 32'd0);
    chk({tag, "_stall_exe"}, {31'b0, bus_if.stall_exe}, 32'd0);
  endtask

  initial begin : driver
    logic [31:0] pc, tgt, paddr;
    bit          v, tk, ptk, fl, found;
    rst = 1'b1;
    bus_if.res_valid = 0; bus_if.res_pc = 0; bus_if.res_taken = 0; bus_if.res_target = 0;
    bus_if.res_pred_taken = 0; bus_if.res_pred_addr = 0; bus_if.flush_req = 0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1;

    // Directed cases: correct prediction, wrong direction, wrong target, PC+4 wrap.
    step(1, 32'h100, 1, 32'h80, 1, 32'h80, 0);
    step(1, 32'h200, 0, 32'h0, 1, 32'h999, 0);
    step(1, 32'h300, 1, 32'h400, 1, 32'h500, 0);
    step(1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10, 0);
    step(1, 32'h500, 1, 32'h600, 0, 32'h0, 0);
    step(1, 32'h700, 1, 32'h800, 1, 32'h800, 1);
    idle(10);

    for (int i = 0; i < 500; i++) begin
      v     = ($urandom_range(0, 99) < 65);
      pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      tk    = $urandom_range(0, 1) == 1;
      tgt   = $urandom & 32'hFFFF_FFFC;
      ptk   = ($urandom_range(0, 3) != 0) ? tk : !tk;
      paddr = ($urandom_range(0, 2) != 0) ? tgt : ($urandom & 32'hFFFF_FFFC);
      fl    = ($urandom_range(0, 39) == 0);
      step(v, pc, tk, tgt, ptk, paddr, fl);
    end
    idle(10);

    // Reset in the middle of an invalidate walk.
    step(1, 32'h40, 1, 32'h44, 1, 32'h48, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if ((inval_left > 0) && (NUM - inval_left == 3)) found = 1;
      else idle(1);
    end
    chk("walk_reached_index3", {31'b0, found}, 32'd1);
    @(negedge clk);
    #4;
    mon_en = 0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midwalk_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1;
    step(0, 0, 0, 0, 0, 0, 1);
    idle(10);

    for (int i = 0; i < 100; i++) begin
      tk  = $urandom_range(0, 1) == 1;
      tgt = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, tk, tgt,
           $urandom_range(0, 1) == 1, tgt ^ {28'b0, 4'($urandom_range(0, 1)) << 2},
           $urandom_range(0, 29) == 0);
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
